// File: rtl/regwb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regwb_pkg : shared types and constants for the write-back arbiter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package regwb_pkg;

    localparam int FIFO_DEPTH  = 2;
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_PC_ADDR = 15;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage
`default_nettype wire

// File: rtl/regwb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regwb_fifo : small write-back buffer with per-slot address taps      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regwb_fifo
    import regwb_pkg::*;
#(
    parameter int  ADDR_W = DEF_ADDR_W,
    parameter type REQ_T  = wb_req_t
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  REQ_T              push_req,
    input  logic              pop,
    output REQ_T              head,
    output logic [CNT_W-1:0]  count,
    output logic [FIFO_DEPTH-1:0] slot_valid,
    output logic [ADDR_W-1:0] slot_addr [FIFO_DEPTH]
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    REQ_T               r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_req;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    // A slot is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_slot
        logic [c_PTR_W-1:0] w_off;
        assign w_off         = c_PTR_W'(i) - r_rd_ptr;
        assign slot_valid[i] = CNT_W'(w_off) < r_count;
        assign slot_addr[i]  = r_mem[i].addr;
    end

endmodule
`default_nettype wire

// File: rtl/regwb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regwb_arbiter : round-robin drain of two write-back buffers into the |
// | register-file write port; optional PC redirect (REGWB_PC_REDIRECT_EN)|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regwb_arbiter
    import regwb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PC_ADDR = DEF_PC_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_wr_en,
    output logic [DATA_W-1:0] pc_wr_data,
    input  logic [ADDR_W-1:0] hz_addr,
    output logic              hz_pending,
    output logic [2:0]        pending_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    logic             w_in_valid [2];
    req_t             w_push_req [2];
    logic [1:0]       w_ready;
    logic [1:0]       w_push;
    logic [1:0]       w_grant;
    logic [1:0]       w_ne;
    logic [1:0]       w_hz_src;
    logic [CNT_W-1:0] w_count [2];
    req_t             w_head [2];
    req_t             w_sel_req;
    logic             w_is_pc;
    logic             w_pc_hz;

    src_e              r_last;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_wdata;

    assign w_in_valid[0] = s0_valid;
    assign w_in_valid[1] = s1_valid;
    assign w_push_req[0] = '{addr: s0_addr, data: s0_data};
    assign w_push_req[1] = '{addr: s1_addr, data: s1_data};

    for (genvar i = 0; i < 2; i++) begin : g_src
        logic [FIFO_DEPTH-1:0] w_slot_valid;
        logic [ADDR_W-1:0]     w_slot_addr [FIFO_DEPTH];
        logic [FIFO_DEPTH-1:0] w_match;

        // Ready is derived from registered occupancy only, so a full buffer never passes through.
        assign w_ready[i] = !rst && (w_count[i] != CNT_W'(FIFO_DEPTH));
        assign w_push[i]  = w_in_valid[i] && w_ready[i];
        assign w_ne[i]    = w_count[i] != '0;

        regwb_fifo #(
            .ADDR_W (ADDR_W),
            .REQ_T  (req_t)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (w_push[i]),
            .push_req   (w_push_req[i]),
            .pop        (w_grant[i]),
            .head       (w_head[i]),
            .count      (w_count[i]),
            .slot_valid (w_slot_valid),
            .slot_addr  (w_slot_addr)
        );

        for (genvar j = 0; j < FIFO_DEPTH; j++) begin : g_cmp
            assign w_match[j] = w_slot_valid[j] && (w_slot_addr[j] == hz_addr);
        end
        assign w_hz_src[i] = |w_match;
    end

    assign w_grant[0] = w_ne[0] && (!w_ne[1] || r_last == SRC_LSU);
    assign w_grant[1] = w_ne[1] && (!w_ne[0] || r_last == SRC_ALU);
    assign w_sel_req  = w_grant[1] ? w_head[1] : w_head[0];
    assign w_is_pc    = w_sel_req.addr == ADDR_W'(PC_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= SRC_LSU;
            r_rf_we    <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= 1'b0;
            if (|w_grant) begin
                r_last <= w_grant[1] ? SRC_LSU : SRC_ALU;
                if (!w_is_pc) begin
                    r_rf_we    <= 1'b1;
                    r_rf_addr  <= w_sel_req.addr;
                    r_rf_wdata <= w_sel_req.data;
                end
            end
        end
    end

`ifdef REGWB_PC_REDIRECT_EN
    logic              r_pc_en;
    logic [DATA_W-1:0] r_pc_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_en   <= 1'b0;
            r_pc_data <= '0;
        end else begin
            r_pc_en <= (|w_grant) && w_is_pc;
            if ((|w_grant) && w_is_pc) begin
                r_pc_data <= w_sel_req.data;
            end
        end
    end

    assign pc_wr_en   = r_pc_en;
    assign pc_wr_data = r_pc_data;
    assign w_pc_hz    = r_pc_en && (hz_addr == ADDR_W'(PC_ADDR));
`else
    // PC-addressed entries still consume their grant but are discarded here.
    assign pc_wr_en   = 1'b0;
    assign pc_wr_data = '0;
    assign w_pc_hz    = 1'b0;
`endif

    assign s0_ready    = w_ready[0];
    assign s1_ready    = w_ready[1];
    assign rf_we       = r_rf_we;
    assign rf_addr     = r_rf_addr;
    assign rf_wdata    = r_rf_wdata;
    assign pending_cnt = 3'(w_count[0]) + 3'(w_count[1]);
    assign hz_pending  = (|w_hz_src) || (r_rf_we && (r_rf_addr == hz_addr)) || w_pc_hz;

endmodule
`default_nettype wire

// File: tb/tb_regwb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regwb_arbiter : queue-based reference model plus directed vectors |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_regwb_arbiter;

    localparam int PC = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s0_valid = 1'b0, s1_valid = 1'b0;
    logic [8:0]  s0_addr = '0, s1_addr = '0, hz_addr = '0;
    logic [31:0] s0_data = '0, s1_data = '0;
    logic        s0_ready, s1_ready, rf_we, pc_wr_en, hz_pending;
    logic [8:0]  rf_addr;
    logic [31:0] rf_wdata, pc_wr_data;
    logic [2:0]  pending_cnt;

    regwb_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data),
        .hz_addr(hz_addr), .hz_pending(hz_pending), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-source queues and a round-robin rule.
    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        q0[$], q1[$];
    ent_t        e;
    int          m_last = 1;
    int          g;
    bit          r0, r1;
    bit          m_we = 0, m_pc_en = 0, m_addr_known = 1;
    logic [8:0]  m_addr = '0;
    logic [31:0] m_wdata = '0, m_pc_data = '0;
    bit          en = 0;
    int          cyc = 0;
    logic [8:0]  log_addr[$];
    int          log_cyc[$];

    function automatic bit m_hz();
        bit h = 0;
        foreach (q0[i]) if (q0[i].addr == hz_addr) h = 1;
        foreach (q1[i]) if (q1[i].addr == hz_addr) h = 1;
        if (m_we && m_addr == hz_addr) h = 1;
        if (m_pc_en && hz_addr == 9'(PC)) h = 1;
        return h;
    endfunction

    always @(posedge clk) begin
        cyc++;
        r0 = !rst && q0.size() < 2;
        r1 = !rst && q1.size() < 2;
        if (rst) begin
            q0.delete(); q1.delete();
            m_last = 1; m_we = 0; m_pc_en = 0; m_addr = '0; m_wdata = '0;
            m_pc_data = '0; m_addr_known = 1;
        end else begin
            g = -1;
            if (q0.size() > 0 && q1.size() > 0) g = (m_last == 1) ? 0 : 1;
            else if (q0.size() > 0) g = 0;
            else if (q1.size() > 0) g = 1;
            m_we = 0;
            m_pc_en = 0;
            if (g >= 0) begin
                e = (g == 0) ? q0.pop_front() : q1.pop_front();
                m_last = g;
                if (e.addr == 9'(PC)) begin
`ifdef REGWB_PC_REDIRECT_EN
                    m_pc_en = 1;
                    m_pc_data = e.data;
`endif
                    m_addr_known = 0;
                end else begin
                    m_we = 1; m_addr = e.addr; m_wdata = e.data; m_addr_known = 1;
                end
            end
            if (s0_valid && r0) q0.push_back('{s0_addr, s0_data});
            if (s1_valid && r1) q1.push_back('{s1_addr, s1_data});
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("rf_we", 64'(rf_we), 64'(m_we));
            chk("pc_wr_en", 64'(pc_wr_en), 64'(m_pc_en));
            chk("pending_cnt", 64'(pending_cnt), 64'(q0.size() + q1.size()));
            chk("s0_ready", 64'(s0_ready), 64'(!rst && q0.size() < 2));
            chk("s1_ready", 64'(s1_ready), 64'(!rst && q1.size() < 2));
            chk("hz_pending", 64'(hz_pending), 64'(m_hz()));
            chk("pc_wr_data", 64'(pc_wr_data), 64'(m_pc_data));
            if (m_addr_known) begin
                chk("rf_addr", 64'(rf_addr), 64'(m_addr));
                chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
            end
            if (rf_we === 1'b1) begin
                log_addr.push_back(rf_addr);
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1; s0_valid = 0; s1_valid = 0;
        tick();
        rst = 0;
    endtask

    task automatic push0(input int a, input int d);
        s0_valid = 1; s0_addr = 9'(a); s0_data = 32'(d);
    endtask

    task automatic push1(input int a, input int d);
        s1_valid = 1; s1_addr = 9'(a); s1_data = 32'(d);
    endtask

    int  i0, i1, maxp, hits;
    bit  a0, a1, saw_block;
    logic [8:0] exp_order [4];

    initial begin
        tick(); tick();
        rst = 0;
        en = 1;
        tick();
        chk("reset rf_we", 64'(rf_we), 64'd0);
        chk("reset rf_addr", 64'(rf_addr), 64'd0);
        chk("reset rf_wdata", 64'(rf_wdata), 64'd0);
        chk("reset pending_cnt", 64'(pending_cnt), 64'd0);
        chk("reset s0_ready", 64'(s0_ready), 64'd1);

        // Single write
        push0(3, 32'hDEADBEEF);
        tick(); s0_valid = 0;
        chk("single pending", 64'(pending_cnt), 64'd1);
        chk("single we early", 64'(rf_we), 64'd0);
        tick();
        chk("single we", 64'(rf_we), 64'd1);
        chk("single addr", 64'(rf_addr), 64'd3);
        chk("single data", 64'(rf_wdata), 64'hDEADBEEF);
        tick();
        chk("single we after", 64'(rf_we), 64'd0);

        // Tie and fairness
        do_reset();
        log_addr.delete(); log_cyc.delete();
        push0(1, 'h11); push1(4, 'h44);
        tick();
        push0(2, 'h12); push1(5, 'h55);
        tick();
        s0_valid = 0; s1_valid = 0;
        chk("tie s1_ready full", 64'(s1_ready), 64'd0);
        repeat (6) tick();
        exp_order[0] = 9'd1; exp_order[1] = 9'd4; exp_order[2] = 9'd2; exp_order[3] = 9'd5;
        chk("tie count", 64'(log_addr.size()), 64'd4);
        for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
            chk("tie order", 64'(log_addr[k]), 64'(exp_order[k]));
            if (k > 0) chk("tie consecutive", 64'(log_cyc[k] - log_cyc[k-1]), 64'd1);
        end

        // Backpressure
        do_reset();
        log_addr.delete(); log_cyc.delete();
        i0 = 0; i1 = 0; maxp = 0; saw_block = 0;
        for (int t = 0; t < 40 && !(i0 == 6 && i1 == 3); t++) begin
            s0_valid = (i0 < 6); s0_addr = 9'(20 + i0); s0_data = 32'(100 + i0);
            s1_valid = (i1 < 3); s1_addr = 9'(30 + i1); s1_data = 32'(200 + i1);
            #1;
            a0 = s0_valid && s0_ready;
            a1 = s1_valid && s1_ready;
            if (s1_valid && !s1_ready) saw_block = 1;
            if (int'(pending_cnt) > maxp) maxp = int'(pending_cnt);
            tick();
            if (a0) i0++;
            if (a1) i1++;
        end
        s0_valid = 0; s1_valid = 0;
        repeat (8) tick();
        chk("bp all accepted", 64'(i0 * 10 + i1), 64'd63);
        chk("bp s1 blocked", 64'(saw_block), 64'd1);
        chk("bp max pending<=4", 64'(maxp <= 4), 64'd1);
        chk("bp writes", 64'(log_addr.size()), 64'd9);
        for (int a = 20; a < 33; a++) begin
            if (a < 26 || a >= 30) begin
                hits = 0;
                foreach (log_addr[k]) if (log_addr[k] == 9'(a)) hits++;
                chk("bp once", 64'(hits), 64'd1);
            end
        end

        // PC redirect
        do_reset();
        push0(PC, 'h100);
        tick();
        push0(3, 'h33);
        tick();
        s0_valid = 0;
        chk("pc rf_we", 64'(rf_we), 64'd0);
`ifdef REGWB_PC_REDIRECT_EN
        chk("pc pulse", 64'(pc_wr_en), 64'd1);
        chk("pc data", 64'(pc_wr_data), 64'h100);
`else
        chk("pc no pulse", 64'(pc_wr_en), 64'd0);
        chk("pc data zero", 64'(pc_wr_data), 64'd0);
`endif
        tick();
        chk("pc next we", 64'(rf_we), 64'd1);
        chk("pc next addr", 64'(rf_addr), 64'd3);
        chk("pc pulse end", 64'(pc_wr_en), 64'd0);

        // Hazard
        do_reset();
        hz_addr = 9'd7;
        push1(7, 'h77);
        tick(); s1_valid = 0;
        chk("hz buffered", 64'(hz_pending), 64'd1);
        tick();
        chk("hz output", 64'(hz_pending), 64'd1);
        tick();
        chk("hz clear", 64'(hz_pending), 64'd0);
        hz_addr = 9'd8;
        push1(7, 'h78);
        #1;
        chk("hz other idle", 64'(hz_pending), 64'd0);
        tick(); s1_valid = 0;
        chk("hz other buffered", 64'(hz_pending), 64'd0);
        tick();
        chk("hz other output", 64'(hz_pending), 64'd0);

        // Reset mid-operation
        do_reset();
        push0(1, 'h1); push1(2, 'h2);
        tick();
        push0(3, 'h3); push1(4, 'h4);
        tick();
        s0_valid = 0; s1_valid = 0;
        chk("mid pending", 64'(pending_cnt), 64'd3);
        rst = 1;
        #1;
        chk("mid ready in rst", 64'(s0_ready), 64'd0);
        tick();
        chk("mid rf_we", 64'(rf_we), 64'd0);
        chk("mid rf_addr", 64'(rf_addr), 64'd0);
        chk("mid rf_wdata", 64'(rf_wdata), 64'd0);
        chk("mid pending0", 64'(pending_cnt), 64'd0);
        chk("mid hz", 64'(hz_pending), 64'd0);
        rst = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("mid no write", 64'(rf_we), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
